// File: rtl/fp_add_subt_seq.sv
// fp_add_subt_seq: sequential IEEE-754 single-precision adder/subtractor.
// One operation at a time, walking IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even in ROUND;
// left undefined, ROUND truncates (round toward zero). Latency is the same either way.
// Ports:
//   CLK           clock, rising edge
//   RST_LN        asynchronous reset, active-high
//   Begin_SUM     start pulse, honoured in IDLE/DONE only
//   ADD_SUBT      0 = X+Y, 1 = X-Y (captured with Begin_SUM)
//   Data_X/Data_Y operands (captured with Begin_SUM)
//   ACK_ADD_SUBT  high while in DONE
//   Result        registered result, updated on ROUND->DONE
//   Overflow      last result saturated to +/-Inf
//   Underflow     last result flushed to signed zero
module fp_add_subt_seq (
    input  logic        CLK,
    input  logic        RST_LN,
    input  logic        Begin_SUM,
    input  logic        ADD_SUBT,
    input  logic [31:0] Data_X,
    input  logic [31:0] Data_Y,
    output logic        ACK_ADD_SUBT,
    output logic [31:0] Result,
    output logic        Overflow,
    output logic        Underflow
);

    localparam int unsigned EW = 8;   // exponent width
    localparam int unsigned FW = 23;  // stored fraction width
    localparam int unsigned XW = 27;  // hidden + fraction + guard/round/sticky
    localparam int unsigned NW = 10;  // signed working exponent
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t            state;
    logic              op_r;
    logic [31:0]       x_r, y_r;
    logic [XW-1:0]     ma_r, mb_r;
    logic [EW-1:0]     exp_r;
    logic              sign_r, eff_sub_r, special_r;
    logic [31:0]       special_val_r;
    logic [XW:0]       sum_r;
    logic [XW-1:0]     norm_m_r;
    logic signed [NW-1:0] norm_e_r;
    logic              zero_r;

    // Leading-zero count over the 27-bit extended mantissa (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [XW-1:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < int'(XW); i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // ALIGN: classify operands, order by magnitude, shift B with sticky.
    logic [EW-1:0]  ex_c, ey_c, ea_c, eb_c, diff_c;
    logic           sx_c, sy_c, swap_c, nan_x_c, nan_y_c, inf_x_c, inf_y_c;
    logic [30:0]    mag_x_c, mag_y_c, a_mag_c, b_mag_c;
    logic [XW-1:0]  ma_ext_c, mb_ext_c, lost_mask_c, mb_al_c;
    logic [4:0]     shamt_c;
    logic           special_c;
    logic [31:0]    special_val_c;

    always_comb begin
        ex_c    = x_r[30:23];
        ey_c    = y_r[30:23];
        sx_c    = x_r[31];
        sy_c    = y_r[31] ^ op_r;       // sign of Y as it enters the sum
        nan_x_c = (ex_c == 8'hFF) && (|x_r[FW-1:0]);
        nan_y_c = (ey_c == 8'hFF) && (|y_r[FW-1:0]);
        inf_x_c = (ex_c == 8'hFF) && !(|x_r[FW-1:0]);
        inf_y_c = (ey_c == 8'hFF) && !(|y_r[FW-1:0]);
        // Denormals collapse to zero magnitude.
        mag_x_c = (ex_c == 8'd0) ? 31'd0 : x_r[30:0];
        mag_y_c = (ey_c == 8'd0) ? 31'd0 : y_r[30:0];
        swap_c  = mag_y_c > mag_x_c;
        a_mag_c = swap_c ? mag_y_c : mag_x_c;
        b_mag_c = swap_c ? mag_x_c : mag_y_c;
        ea_c    = a_mag_c[30:23];
        eb_c    = b_mag_c[30:23];
        ma_ext_c = (ea_c == 8'd0) ? '0 : {1'b1, a_mag_c[FW-1:0], 3'b000};
        mb_ext_c = (eb_c == 8'd0) ? '0 : {1'b1, b_mag_c[FW-1:0], 3'b000};
        diff_c   = ea_c - eb_c;
        shamt_c  = (diff_c > 8'd26) ? 5'd26 : diff_c[4:0];
        lost_mask_c = (XW'(1) << shamt_c) - XW'(1);
        mb_al_c  = (mb_ext_c >> shamt_c) | {26'd0, |(mb_ext_c & lost_mask_c)};

        special_c     = 1'b1;
        special_val_c = QNAN;
        if (nan_x_c || nan_y_c) begin
            special_val_c = QNAN;
        end else if (inf_x_c && inf_y_c) begin
            special_val_c = (sx_c != sy_c) ? QNAN : {sx_c, 8'hFF, 23'd0};
        end else if (inf_x_c) begin
            special_val_c = {sx_c, 8'hFF, 23'd0};
        end else if (inf_y_c) begin
            special_val_c = {sy_c, 8'hFF, 23'd0};
        end else begin
            special_c = 1'b0;
        end
    end

    // ADD: magnitudes are ordered, so the subtraction never goes negative.
    logic [XW:0] sum_c;
    always_comb begin
        if (eff_sub_r) sum_c = {1'b0, ma_r} - {1'b0, mb_r};
        else           sum_c = {1'b0, ma_r} + {1'b0, mb_r};
    end

    // NORM: single-step right shift on carry, else left shift by lzc.
    logic [4:0]           lz_c;
    logic [XW-1:0]        norm_m_c;
    logic signed [NW-1:0] norm_e_c;
    always_comb begin
        lz_c = lzc27(sum_r[XW-1:0]);
        if (sum_r[XW]) begin
            norm_m_c = {sum_r[XW:2], sum_r[1] | sum_r[0]};
            norm_e_c = $signed({2'b00, exp_r}) + 10'sd1;
        end else begin
            norm_m_c = sum_r[XW-1:0] << lz_c;
            norm_e_c = $signed({2'b00, exp_r}) - $signed({5'd0, lz_c});
        end
    end

    // ROUND: rounding, then saturation/flush and final packing.
    logic [24:0]          rm_c;
    logic signed [NW-1:0] re_c;
    logic [31:0]          res_c;
    logic                 ovf_c, unf_c;
    always_comb begin
        rm_c = {1'b0, norm_m_r[XW-1:3]};
        re_c = norm_e_r;
`ifdef FP_ROUND_NEAREST_EN
        // Guard set and (round | sticky | lsb) rounds up: nearest, ties to even.
        if (norm_m_r[2] && (norm_m_r[1] || norm_m_r[0] || norm_m_r[3])) begin
            rm_c = rm_c + 25'd1;
        end
        if (rm_c[24]) begin
            rm_c = rm_c >> 1;
            re_c = re_c + 10'sd1;
        end
`endif
        res_c = {sign_r, re_c[EW-1:0], rm_c[FW-1:0]};
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (special_r) begin
            res_c = special_val_r;
        end else if (zero_r) begin
            res_c = 32'd0;
        end else if (re_c >= 10'sd255) begin
            res_c = {sign_r, 8'hFF, 23'd0};
            ovf_c = 1'b1;
        end else if (re_c <= 10'sd0) begin
            res_c = {sign_r, 31'd0};
            unf_c = 1'b1;
        end
    end

`ifndef FP_ROUND_NEAREST_EN
    logic unused_grs;
    assign unused_grs = ^norm_m_r[2:0];
`endif

    // Sequencer and all datapath registers.
    always_ff @(posedge CLK or posedge RST_LN) begin
        if (RST_LN) begin
            state         <= S_IDLE;
            ACK_ADD_SUBT  <= 1'b0;
            Result        <= 32'd0;
            Overflow      <= 1'b0;
            Underflow     <= 1'b0;
            op_r          <= 1'b0;
            x_r           <= 32'd0;
            y_r           <= 32'd0;
            ma_r          <= '0;
            mb_r          <= '0;
            exp_r         <= '0;
            sign_r        <= 1'b0;
            eff_sub_r     <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= 32'd0;
            sum_r         <= '0;
            norm_m_r      <= '0;
            norm_e_r      <= '0;
            zero_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Begin_SUM) begin
                        op_r         <= ADD_SUBT;
                        x_r          <= Data_X;
                        y_r          <= Data_Y;
                        ACK_ADD_SUBT <= 1'b0;
                        state        <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    ma_r          <= ma_ext_c;
                    mb_r          <= mb_al_c;
                    exp_r         <= ea_c;
                    sign_r        <= swap_c ? sy_c : sx_c;
                    eff_sub_r     <= sx_c ^ sy_c;
                    special_r     <= special_c;
                    special_val_r <= special_val_c;
                    state         <= S_ADD;
                end
                S_ADD: begin
                    sum_r <= sum_c;
                    state <= S_NORM;
                end
                S_NORM: begin
                    norm_m_r <= norm_m_c;
                    norm_e_r <= norm_e_c;
                    zero_r   <= (sum_r == '0);
                    state    <= S_ROUND;
                end
                S_ROUND: begin
                    Result       <= res_c;
                    Overflow     <= ovf_c;
                    Underflow    <= unf_c;
                    ACK_ADD_SUBT <= 1'b1;
                    state        <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_subt_seq.sv
module tb_fp_add_subt_seq;

    logic        CLK = 1'b0;
    logic        RST_LN;
    logic        Begin_SUM;
    logic        ADD_SUBT;
    logic [31:0] Data_X, Data_Y;
    logic        ACK_ADD_SUBT;
    logic [31:0] Result;
    logic        Overflow, Underflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    fp_add_subt_seq dut (
        .CLK          (CLK),
        .RST_LN       (RST_LN),
        .Begin_SUM    (Begin_SUM),
        .ADD_SUBT     (ADD_SUBT),
        .Data_X       (Data_X),
        .Data_Y       (Data_Y),
        .ACK_ADD_SUBT (ACK_ADD_SUBT),
        .Result       (Result),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    // Reference: exact sum of the operands as big integers in units of 2^-149,
    // rounded to 24 significant bits, then saturated or flushed. Returns {ovf, unf, result}.
    function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic op);
        logic         sx, sy, s;
        int           ex, ey, p, e;
        logic [279:0] mx, my, m, mr;
        sx = x[31];
        sy = y[31] ^ op;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return {2'b00, 32'h7FC00000};
        if (ex == 255 && ey == 255) return (sx != sy) ? {2'b00, 32'h7FC00000} : {2'b00, sx, 8'hFF, 23'd0};
        if (ex == 255) return {2'b00, sx, 8'hFF, 23'd0};
        if (ey == 255) return {2'b00, sy, 8'hFF, 23'd0};
        mx = (ex == 0) ? 280'd0 : (280'({1'b1, x[22:0]}) << (ex - 1));
        my = (ey == 0) ? 280'd0 : (280'({1'b1, y[22:0]}) << (ey - 1));
        s  = 1'b0;
        if (sx == sy)     begin m = mx + my; s = sx; end
        else if (mx > my) begin m = mx - my; s = sx; end
        else if (my > mx) begin m = my - mx; s = sy; end
        else              m = 280'd0;
        if (m == 280'd0) return 34'd0;
        p = 0;
        for (int i = 0; i < 280; i++) if (m[i]) p = i;
        e = p - 22;
        if (p > 23) begin
            mr = m >> (p - 23);
`ifdef FP_ROUND_NEAREST_EN
            begin
                logic [279:0] rem, half;
                rem  = m & ((280'd1 << (p - 23)) - 280'd1);
                half = 280'd1 << (p - 24);
                if (rem > half || (rem == half && mr[0])) mr = mr + 280'd1;
                if (mr[24]) begin mr = mr >> 1; e = e + 1; end
            end
`endif
        end else begin
            mr = m << (23 - p);
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, 8'(e), mr[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned c;
        logic        s;
        logic [22:0] m;
        logic [7:0]  e;
        c = $urandom_range(0, 19);
        s = 1'($urandom);
        m = 23'($urandom);
        case (c)
            0: return {s, 31'd0};
            1: return {s, 8'd0, m | 23'd1};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, m | 23'd1};
            4, 5: e = 8'($urandom_range(248, 254));
            6, 7: e = 8'($urandom_range(1, 8));
            default: e = 8'($urandom_range(110, 140));
        endcase
        return {s, e, m};
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic op);
        Begin_SUM = 1'b1;
        Data_X    = x;
        Data_Y    = y;
        ADD_SUBT  = op;
    endtask

    // Drop Begin, scramble the operand bus, count edges until ACK (bounded).
    // Also reports the ACK level one edge after the start and whether Result moved early.
    task automatic wait_ack(output int lat, output logic first_ack, output logic held_ok);
        logic [31:0] prev;
        prev = Result;
        @(negedge CLK);
        Begin_SUM = 1'b0;
        Data_X    = $urandom;
        Data_Y    = $urandom;
        ADD_SUBT  = 1'($urandom);
        first_ack = ACK_ADD_SUBT;
        held_ok   = 1'b1;
        lat       = 0;
        while (ACK_ADD_SUBT !== 1'b1 && lat < 12) begin
            if (Result !== prev) held_ok = 1'b0;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset();
        RST_LN = 1'b1; Begin_SUM = 1'b0; ADD_SUBT = 1'b0; Data_X = '0; Data_Y = '0;
        #1;
        n_checks++;
        if ({ACK_ADD_SUBT, Result, Overflow, Underflow} !== 35'd0)
            $display("FAIL reset_state: ack=%b result=%h ovf=%b unf=%b, required all zero",
                     ACK_ADD_SUBT, Result, Overflow, Underflow);
        else n_pass++;
        repeat (2) @(negedge CLK);
        RST_LN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        logic [31:0] dx[10], dy[10], dr[10];
        logic        dop[10], dov[10], dun[10];
        int          lat;
        logic        fa, ho;
        dx = '{32'h3F800000, 32'h40400000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
               32'h3F800000, 32'h00800000, 32'h00000001, 32'h7F800001, 32'hFF800000};
        dy = '{32'h3F800000, 32'h40400000, 32'h7F7FFFFF, 32'h7F800000, 32'h33C00000,
               32'h33800000, 32'h00C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        dop = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef FP_ROUND_NEAREST_EN
        dr = '{32'h40000000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800001,
               32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00000, 32'hFF800000};
`else
        dr = '{32'h40000000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
               32'h3F800000, 32'h80000000, 32'h3F800000, 32'h7FC00000, 32'hFF800000};
`endif
        dov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        dun = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            start_op(dx[i], dy[i], dop[i]);
            wait_ack(lat, fa, ho);
            n_checks++;
            if (lat != 4) $display("FAIL directed_latency[%0d]: got %0d edges, required 4", i, lat);
            else n_pass++;
            n_checks++;
            if (Result !== dr[i]) $display("FAIL directed_result[%0d]: got %h, required %h", i, Result, dr[i]);
            else n_pass++;
            n_checks++;
            if ({Overflow, Underflow} !== {dov[i], dun[i]})
                $display("FAIL directed_flags[%0d]: got ovf=%b unf=%b, required ovf=%b unf=%b",
                         i, Overflow, Underflow, dov[i], dun[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        logic        op, fa, ho;
        logic [33:0] exp_v;
        int          lat;
        for (int i = 0; i < 400; i++) begin
            x  = rand_fp();
            y  = rand_fp();
            op = 1'($urandom);
            if ($urandom_range(0, 2) == 0 && x[30:23] != 8'hFF) begin
                // Near-cancellation: same exponent, nearby fraction.
                y        = x;
                y[31]    = 1'($urandom);
                y[5:0]   = 6'($urandom);
                if ($urandom_range(0, 1) == 1 && x[30:23] > 8'd1) y[30:23] = x[30:23] - 8'd1;
            end
            exp_v = ref_model(x, y, op);
            @(negedge CLK);
            start_op(x, y, op);
            wait_ack(lat, fa, ho);
            n_checks++;
            if (lat != 4) $display("FAIL random_latency: x=%h y=%h got %0d edges, required 4", x, y, lat);
            else n_pass++;
            n_checks++;
            if ({Overflow, Underflow, Result} !== exp_v)
                $display("FAIL random_result: x=%h y=%h op=%b got ovf=%b unf=%b res=%h, required ovf=%b unf=%b res=%h",
                         x, y, op, Overflow, Underflow, Result, exp_v[33], exp_v[32], exp_v[31:0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic        op, fa, ho;
        logic [33:0] exp_v;
        int          lat;
        for (int i = 0; i < 20; i++) begin
            x = rand_fp(); y = rand_fp(); op = 1'($urandom);
            exp_v = ref_model(x, y, op);
            start_op(x, y, op);   // issued in the same cycle DONE is observed
            wait_ack(lat, fa, ho);
            n_checks++;
            if (fa !== 1'b0) $display("FAIL b2b_ack_fall: ack=%b one edge after start, required 0", fa);
            else n_pass++;
            n_checks++;
            if (ho !== 1'b1) $display("FAIL b2b_result_hold: Result changed before ACK, required stable");
            else n_pass++;
            n_checks++;
            if (lat != 4 || {Overflow, Underflow, Result} !== exp_v)
                $display("FAIL b2b_result: lat=%0d res=%h ovf=%b unf=%b, required lat=4 res=%h ovf=%b unf=%b",
                         lat, Result, Overflow, Underflow, exp_v[31:0], exp_v[33], exp_v[32]);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_begin();
        logic [33:0] exp_v;
        int          acks;
        exp_v = ref_model(32'h3F800000, 32'h3F800000, 1'b0);
        @(negedge CLK);
        start_op(32'h3F800000, 32'h3F800000, 1'b0);
        @(negedge CLK);                                  // ALIGN
        Begin_SUM = 1'b0;
        @(negedge CLK);                                  // ADD: second pulse must be dropped
        start_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        @(negedge CLK);                                  // NORM
        Begin_SUM = 1'b0;
        @(negedge CLK);                                  // ROUND
        n_checks++;
        if (ACK_ADD_SUBT !== 1'b0) $display("FAIL ignore_ack_early: ack=%b in ROUND, required 0", ACK_ADD_SUBT);
        else n_pass++;
        @(negedge CLK);                                  // DONE
        n_checks++;
        if (ACK_ADD_SUBT !== 1'b1 || {Overflow, Underflow, Result} !== exp_v)
            $display("FAIL ignore_first_result: ack=%b res=%h, required ack=1 res=%h", ACK_ADD_SUBT, Result, exp_v[31:0]);
        else n_pass++;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (ACK_ADD_SUBT !== 1'b1 || Result !== exp_v[31:0]) acks++;
        end
        n_checks++;
        if (acks != 0) $display("FAIL ignore_no_second_op: %0d cycles with ack low or result changed, required 0", acks);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [33:0] exp_v;
        int          lat, bad;
        logic        fa, ho;
        @(negedge CLK);
        start_op(32'h40400000, 32'h3F800000, 1'b0);     // leaves a nonzero Result behind
        wait_ack(lat, fa, ho);
        start_op(32'h3F800000, 32'h40000000, 1'b1);
        @(negedge CLK); Begin_SUM = 1'b0;                // ALIGN
        @(negedge CLK);                                  // ADD
        @(negedge CLK);                                  // NORM
        RST_LN = 1'b1;
        #1;
        n_checks++;
        if ({ACK_ADD_SUBT, Result, Overflow, Underflow} !== 35'd0)
            $display("FAIL abort_reset_state: ack=%b result=%h ovf=%b unf=%b, required all zero",
                     ACK_ADD_SUBT, Result, Overflow, Underflow);
        else n_pass++;
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (ACK_ADD_SUBT !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL abort_no_ack: ack high %0d cycles during reset, required 0", bad);
        else n_pass++;
        exp_v = ref_model(32'hC0A00000, 32'h3E800000, 1'b1);
        RST_LN = 1'b0;
        start_op(32'hC0A00000, 32'h3E800000, 1'b1);     // first edge after release
        wait_ack(lat, fa, ho);
        n_checks++;
        if (lat != 4 || {Overflow, Underflow, Result} !== exp_v)
            $display("FAIL abort_fresh_op: lat=%0d res=%h, required lat=4 res=%h", lat, Result, exp_v[31:0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_begin();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_add_subt_seq.md
FP_ADD_SUBT_SEQ -- requirements
Module: fp_add_subt_seq

Interface
REQ-001 CLK  input  1  system clock; all state updates on the rising edge.
REQ-002 RST_LN  input  1  reset; asynchronous, active-high.
REQ-003 Begin_SUM  input  1  start request; one-cycle pulse from the CORDIC controller.
REQ-004 ADD_SUBT  input  1  operation select: 0 = X+Y, 1 = X-Y; sampled with Begin_SUM.
REQ-005 Data_X  input  32  IEEE-754 single-precision operand X; sampled with Begin_SUM.
REQ-006 Data_Y  input  32  IEEE-754 single-precision operand Y; sampled with Begin_SUM.
REQ-007 ACK_ADD_SUBT  output  1  result valid; level signal.
REQ-008 Result  output  32  IEEE-754 single-precision result; registered.
REQ-009 Overflow  output  1  the last result saturated to ±Inf.
REQ-010 Underflow  output  1  the last result was flushed to zero because its exponent was too small.

Function
REQ-011 The FSM SHALL have six states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
REQ-012 In IDLE or DONE, a sampled Begin_SUM=1 SHALL capture ADD_SUBT, Data_X and Data_Y and go to ALIGN; Begin_SUM=0 SHALL hold the state.
REQ-013 ALIGN, ADD, NORM and ROUND SHALL each last exactly one cycle, and ROUND SHALL go to DONE.
REQ-014 Begin_SUM in ALIGN, ADD, NORM or ROUND SHALL be ignored.
REQ-015 ACK_ADD_SUBT SHALL be 1 iff the state is DONE (Moore output).
- Begin_SUM sampled at edge k -> ACK rises after edge k+4.
- ACK falls after the edge that samples a new Begin_SUM.
REQ-016 Result, Overflow and Underflow SHALL update only on the ROUND->DONE edge and hold until the next ROUND->DONE edge.
REQ-017 ALIGN SHALL order the operands so that |A| >= |B|.
- Mantissas are 24 bits, hidden bit included, extended by guard, round and sticky bits (27 bits total).
- B is shifted right by the exponent difference.
- The shift saturates at 26; all shifted-out bits OR into sticky.
REQ-018 ADD SHALL compute the effective operation from the sign of X, the sign of Y and ADD_SUBT, using a 28-bit add or subtract with a carry bit; the result sign is the sign of A, adjusted for the operation.
REQ-019 NORM SHALL normalise in one cycle.
- Carry out set: shift right by 1, exponent +1, sticky kept.
- Otherwise: shift left by the leading-zero count, exponent reduced by the same amount.
REQ-020 A zero magnitude after ADD, including exact cancellation, SHALL produce +0 (0x00000000).
REQ-021 Denormal inputs SHALL be treated as zero.
REQ-022 A final exponent <= 0 SHALL give a signed zero with Underflow=1.
REQ-023 A final exponent >= 255 SHALL give signed Inf (exponent 0xFF, mantissa 0) with Overflow=1.
REQ-024 Special operands:
- Either input NaN -> 0x7FC00000.
- Inf ± finite -> that Inf.
- Inf - Inf (effective) -> 0x7FC00000.
- None of these set Overflow or Underflow.

Reset
REQ-025 RST_LN=1 SHALL immediately force IDLE, ACK_ADD_SUBT=0, Result=0x00000000, Overflow=0, Underflow=0, and clear all internal datapath registers.
REQ-026 Reset during ALIGN..ROUND SHALL abort the operation with no ACK; after release the block SHALL accept a new Begin_SUM on the first clock edge.

Configuration
REQ-027 The macro FP_ROUND_NEAREST_EN SHALL select the rounding applied in ROUND.
- Defined: round-to-nearest-even using guard/round/sticky; a mantissa carry from rounding increments the exponent and may cause overflow per REQ-023.
- Undefined: truncation (round toward zero); guard/round/sticky discarded.
- Latency is identical in both builds.

Verification
REQ-028 Add: X=0x3F800000, Y=0x3F800000, ADD_SUBT=0, Begin at edge k -> Result=0x40000000, ACK high after edge k+4, flags 0.
REQ-029 Cancellation: X=0x40400000, Y=0x40400000, ADD_SUBT=1 -> Result=0x00000000, Underflow=0.
REQ-030 Overflow: X=0x7F7FFFFF, Y=0x7F7FFFFF, ADD_SUBT=0 -> Result=0x7F800000, Overflow=1.
REQ-031 Special operands: X=0x7F800000, Y=0x7F800000, ADD_SUBT=1 -> Result=0x7FC00000, flags 0.
REQ-032 Rounding: X=0x3F800000, Y=0x33C00000, ADD_SUBT=0 -> Result=0x3F800001 with FP_ROUND_NEAREST_EN, 0x3F800000 without; Y=0x33800000 -> 0x3F800000 in both builds (tie to even).
REQ-033 Handshake and reset:
- Begin_SUM pulsed again in ADD -> ignored; exactly one ACK with the first result.
- RST_LN asserted in NORM -> ACK stays 0, Result=0; a fresh Begin after release completes normally.
